// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle MIPS control FSM sequencing fetch/decode/execute/memory/writeback
// Inputs : clk, reset (async, active-low), op/funct from IR, flagZ (ALU zero), mem_ready (memory handshake)
// Outputs: pcwrite, iord, memread, memwrite, irwrite, memtoreg, regdst, wdsel_pc, regwrite,
//          alusrca, alusrcb, zeroext, pcsrc, alucontrol, exc, state (debug)
// Optional: define CTRL_ILLEGAL_EXC_EN to turn the ILLEGAL state into a one-cycle exception pulse
module multicycle_controller #(
  parameter int ALUFN_W = 5,
  parameter logic [ALUFN_W-1:0] ALU_ADD  = 5'b00001,
  parameter logic [ALUFN_W-1:0] ALU_SUB  = 5'b10001,
  parameter logic [ALUFN_W-1:0] ALU_AND  = 5'b01000,
  parameter logic [ALUFN_W-1:0] ALU_OR   = 5'b01110,
  parameter logic [ALUFN_W-1:0] ALU_XOR  = 5'b00110,
  parameter logic [ALUFN_W-1:0] ALU_NOR  = 5'b01001,
  parameter logic [ALUFN_W-1:0] ALU_SLT  = 5'b10111,
  parameter logic [ALUFN_W-1:0] ALU_SLTU = 5'b11011,
  parameter logic [ALUFN_W-1:0] ALU_SLL  = 5'b00010,
  parameter logic [ALUFN_W-1:0] ALU_SRL  = 5'b10010,
  parameter logic [ALUFN_W-1:0] ALU_SRA  = 5'b11010,
  parameter logic [ALUFN_W-1:0] ALU_LUI  = 5'b00100,
  parameter int RESET_PC_HOLD = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               flagZ,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               irwrite,
  output logic               memtoreg,
  output logic [1:0]         regdst,
  output logic               wdsel_pc,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic               zeroext,
  output logic [1:0]         pcsrc,
  output logic [ALUFN_W-1:0] alucontrol,
  output logic               exc,
  output logic [3:0]         state
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE, ALUWB,
    IMMEX, IMMWB, BRANCH, JUMP, JAL, JR, JALR, ILLEGAL
  } state_t;
  localparam int HW = (RESET_PC_HOLD > 0) ? $clog2(RESET_PC_HOLD + 1) : 1;
  state_t st, nxt, dec_nxt;
  logic [HW-1:0] hold;
  logic hold_done, fetch_go;
  logic r_ok, i_ok;
  logic [ALUFN_W-1:0] r_alu, i_alu;
  assign state = st;
  assign hold_done = (hold == HW'(RESET_PC_HOLD));
  assign fetch_go = mem_ready && hold_done;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st   <= FETCH;
      hold <= '0;
    end else begin
      st <= nxt;
      if (!hold_done) hold <= hold + 1'b1;
    end
  end
  always_comb begin
    r_ok  = 1'b1;
    r_alu = ALU_ADD;
    case (funct)
      6'h20: r_alu = ALU_ADD;
      6'h22: r_alu = ALU_SUB;
      6'h24: r_alu = ALU_AND;
      6'h25: r_alu = ALU_OR;
      6'h26: r_alu = ALU_XOR;
      6'h27: r_alu = ALU_NOR;
      6'h2A: r_alu = ALU_SLT;
      6'h2B: r_alu = ALU_SLTU;
      6'h00: r_alu = ALU_SLL;
      6'h02: r_alu = ALU_SRL;
      6'h03: r_alu = ALU_SRA;
      default: r_ok = 1'b0;
    endcase
  end
  always_comb begin
    i_ok  = 1'b1;
    i_alu = ALU_ADD;
    case (op)
      6'h08: i_alu = ALU_ADD;
      6'h0A: i_alu = ALU_SLT;
      6'h0C: i_alu = ALU_AND;
      6'h0D: i_alu = ALU_OR;
      6'h0E: i_alu = ALU_XOR;
      6'h0F: i_alu = ALU_LUI;
      default: i_ok = 1'b0;
    endcase
  end
  // jr/jalr share op 0 with R-type, so they are split out before the funct table
  always_comb begin
    dec_nxt = ILLEGAL;
    if (op == 6'h23 || op == 6'h2B) dec_nxt = MEMADR;
    else if (op == 6'h00) dec_nxt = (funct == 6'h08) ? JR : (funct == 6'h09) ? JALR : r_ok ? RTYPE : ILLEGAL;
    else if (op == 6'h04 || op == 6'h05) dec_nxt = BRANCH;
    else if (i_ok) dec_nxt = IMMEX;
    else if (op == 6'h02) dec_nxt = JUMP;
    else if (op == 6'h03) dec_nxt = JAL;
  end
  // outputs are forced to their idle values while reset is held so no strobe outlives it
  always_comb begin
    nxt        = st;
    pcwrite    = 1'b0;
    iord       = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 2'b00;
    wdsel_pc   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    zeroext    = 1'b0;
    pcsrc      = 2'b00;
    alucontrol = ALU_ADD;
`ifdef CTRL_ILLEGAL_EXC_EN
    exc        = 1'b0;
`endif
    if (reset) begin
      case (st)
        FETCH: begin
          memread = 1'b1;
          alusrcb = 2'b01;
          irwrite = fetch_go;
          pcwrite = fetch_go;
          nxt     = fetch_go ? DECODE : FETCH;
        end
        DECODE: begin
          alusrcb = 2'b11;
          nxt     = dec_nxt;
        end
        MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          nxt     = (op == 6'h23) ? MEMRD : MEMWR;
        end
        MEMRD: begin
          iord    = 1'b1;
          memread = 1'b1;
          nxt     = mem_ready ? MEMWB : MEMRD;
        end
        MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
          nxt      = FETCH;
        end
        MEMWR: begin
          iord     = 1'b1;
          memwrite = 1'b1;
          nxt      = mem_ready ? FETCH : MEMWR;
        end
        RTYPE: begin
          alusrca    = 1'b1;
          alucontrol = r_alu;
          nxt        = ALUWB;
        end
        ALUWB: begin
          regdst   = 2'b01;
          regwrite = 1'b1;
          nxt      = FETCH;
        end
        IMMEX: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          alucontrol = i_alu;
          zeroext    = (op == 6'h0C) || (op == 6'h0D) || (op == 6'h0E);
          nxt        = IMMWB;
        end
        IMMWB: begin
          regwrite = 1'b1;
          nxt      = FETCH;
        end
        BRANCH: begin
          alusrca    = 1'b1;
          alucontrol = ALU_SUB;
          pcsrc      = 2'b01;
          pcwrite    = (op == 6'h04) ? flagZ : ~flagZ;
          nxt        = FETCH;
        end
        JUMP: begin
          pcsrc   = 2'b10;
          pcwrite = 1'b1;
          nxt     = FETCH;
        end
        JAL: begin
          pcsrc    = 2'b10;
          pcwrite  = 1'b1;
          regdst   = 2'b10;
          wdsel_pc = 1'b1;
          regwrite = 1'b1;
          nxt      = FETCH;
        end
        JR: begin
          pcsrc   = 2'b11;
          pcwrite = 1'b1;
          nxt     = FETCH;
        end
        JALR: begin
          pcsrc    = 2'b11;
          pcwrite  = 1'b1;
          regdst   = 2'b01;
          wdsel_pc = 1'b1;
          regwrite = 1'b1;
          nxt      = FETCH;
        end
        ILLEGAL: begin
`ifdef CTRL_ILLEGAL_EXC_EN
          exc     = 1'b1;
          pcsrc   = 2'b10;
          pcwrite = 1'b1;
`endif
          nxt = FETCH;
        end
        default: nxt = FETCH;
      endcase
    end
  end
`ifndef CTRL_ILLEGAL_EXC_EN
  assign exc = 1'b0;
`endif
endmodule
